// File: rtl/lsu_pkg.sv
// Shared RV32I load/store width codes and the LSU state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_t;

    // Stores only have signed-width codes; the unsigned variants are load-only.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side pins of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_i;
    logic              store_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              ready_o;
    logic              valid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  req_i, store_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        output ready_o, valid_o, rdata_o, err_o, mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_i, store_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        input  ready_o, valid_o, rdata_o, err_o, mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'h0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'h0, half_sel};
            default: rdata_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (funct3_i)
            F3_B:    merged_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_H:    merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, RMW for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    load_store_unit_if.slave  bus
);
    lsu_state_t        state_q;
    logic              ready_q, valid_q, err_q, mem_we_q;
    logic [31:0]       rdata_q, mem_wdata_q, wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic [ADDR_W-1:0] addr_fix;
    logic              trap;
    logic [31:0]       ext_rdata, merged;

    // Halfword/word accesses are aligned down; in trap builds any change means misaligned.
    always_comb begin
        addr_fix = bus.addr_i;
        if (bus.funct3_i[1:0] == 2'b01)
            addr_fix[0] = 1'b0;
        else if (bus.funct3_i[1:0] == 2'b10)
            addr_fix[1:0] = 2'b00;
    end

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap = !f3_legal(bus.store_i, bus.funct3_i) || (addr_fix != bus.addr_i);
`else
        trap = !f3_legal(bus.store_i, bus.funct3_i);
`endif
    end

    lsu_align u_align (
        .word_i   (bus.mem_rdata_i),
        .wdata_i  (wdata_q),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .rdata_o  (ext_rdata),
        .merged_o (merged)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_i) begin
                        f3_q    <= bus.funct3_i;
                        off_q   <= addr_fix[1:0];
                        wdata_q <= bus.wdata_i;
                        ready_q <= 1'b0;
                        if (trap) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            mem_addr_q <= {addr_fix[ADDR_W-1:2], 2'b00};
                            if (!bus.store_i) begin
                                state_q <= LOAD;
                            end else if (bus.funct3_i == F3_W) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.wdata_i;
                                state_q     <= STORE;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= ext_rdata;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                STORE: begin
                    mem_we_q <= 1'b0;
                    valid_q  <= 1'b1;
                    state_q  <= RESP;
                end
                // The old word is consumed here, so the merged word is the registered copy.
                RMW_RD: begin
                    mem_wdata_q <= merged;
                    mem_we_q    <= 1'b1;
                    state_q     <= RMW_WR;
                end
                RMW_WR: begin
                    mem_we_q <= 1'b0;
                    valid_q  <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    valid_q  <= 1'b0;
                    err_q    <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.valid_o     = valid_q;
    assign bus.err_o       = err_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word-organised memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem [0:63];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we_o)
            mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output int wes,
                       output logic [31:0] rd, output logic er);
        lat = 0;
        wes = 0;
        rd  = '0;
        er  = 1'b0;
        bus.req_i    = 1'b1;
        bus.store_i  = st;
        bus.funct3_i = f3;
        bus.addr_i   = a;
        bus.wdata_i  = wd;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (bus.mem_we_o) wes++;
            if (bus.valid_o) begin
                lat = i;
                rd  = bus.rdata_o;
                er  = bus.err_o;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, wes, pulses;
        logic [31:0] rd;
        logic        er;

        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.req_i    = 1'b0;
        bus.store_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.addr_i   = '0;
        bus.wdata_i  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8000_00F0;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'h5555_5555;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, bus.ready_o}, 32'd1);
        check("rst_valid", {31'h0, bus.valid_o}, 32'd0);
        check("rst_err", {31'h0, bus.err_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_we", {31'h0, bus.mem_we_o}, 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'h0);
        check("rst_wdata", bus.mem_wdata_o, 32'h0);
        rst = 1'b0;

        txn(1'b0, F3_B, 32'h10, 32'h0, lat, wes, rd, er);
        check("lb_rdata", rd, 32'hFFFF_FFF0);
        check("lb_lat", lat, 32'd2);
        check("lb_err", {31'h0, er}, 32'd0);
        check("lb_we", wes, 32'd0);

        txn(1'b0, F3_BU, 32'h10, 32'h0, lat, wes, rd, er);
        check("lbu_rdata", rd, 32'h0000_00F0);

        txn(1'b1, F3_B, 32'h22, 32'h0000_00AB, lat, wes, rd, er);
        check("sb_mem", mem[8], 32'h11AB_3344);
        check("sb_we_cycles", wes, 32'd1);
        check("sb_lat", lat, 32'd3);
        check("sb_err", {31'h0, er}, 32'd0);

        txn(1'b1, F3_H, 32'h20, 32'h0000_BEEF, lat, wes, rd, er);
        check("sh_mem", mem[8], 32'h11AB_BEEF);

        txn(1'b1, F3_W, 32'h24, 32'hDEAD_BEEF, lat, wes, rd, er);
        check("sw_mem", mem[9], 32'hDEAD_BEEF);
        check("sw_lat", lat, 32'd2);
        check("sw_we_cycles", wes, 32'd1);

        txn(1'b0, F3_W, 32'h24, 32'h0, lat, wes, rd, er);
        check("lw_rdata", rd, 32'hDEAD_BEEF);

        txn(1'b0, F3_H, 32'h26, 32'h0, lat, wes, rd, er);
        check("lh_rdata", rd, 32'hFFFF_DEAD);

        txn(1'b0, F3_W, 32'h21, 32'h0, lat, wes, rd, er);
        check("lw_mis_we", wes, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_err", {31'h0, er}, 32'd1);
        check("lw_mis_lat", lat, 32'd1);
`else
        check("lw_mis_err", {31'h0, er}, 32'd0);
        check("lw_mis_lat", lat, 32'd2);
        check("lw_mis_rdata", rd, 32'h11AB_BEEF);
`endif

        txn(1'b1, F3_H, 32'h23, 32'h0000_1234, lat, wes, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check("sh_mis_err", {31'h0, er}, 32'd1);
        check("sh_mis_mem", mem[8], 32'h11AB_BEEF);
        check("sh_mis_we", wes, 32'd0);
`else
        check("sh_mis_err", {31'h0, er}, 32'd0);
        check("sh_mis_mem", mem[8], 32'h1234_BEEF);
`endif

        txn(1'b0, 3'b011, 32'h20, 32'h0, lat, wes, rd, er);
        check("f3_011_err", {31'h0, er}, 32'd1);
        check("f3_011_lat", lat, 32'd1);
        check("f3_011_we", wes, 32'd0);

        // Reset lands while the SB is in RMW_RD.
        bus.req_i    = 1'b1;
        bus.store_i  = 1'b1;
        bus.funct3_i = F3_B;
        bus.addr_i   = 32'h30;
        bus.wdata_i  = 32'h0000_00AA;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        check("rmwrd_we", {31'h0, bus.mem_we_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", {31'h0, bus.ready_o}, 32'd1);
        check("rst_mid_valid", {31'h0, bus.valid_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_mem", mem[12], 32'h5555_5555);

        // Request held high through LOAD and RESP must produce a single response.
        pulses = 0;
        bus.req_i    = 1'b1;
        bus.store_i  = 1'b0;
        bus.funct3_i = F3_W;
        bus.addr_i   = 32'h24;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o) pulses++;
        end
        bus.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o) pulses++;
        end
        check("held_req_pulses", pulses, 32'd1);
        check("held_req_ready", {31'h0, bus.ready_o}, 32'd1);
        check("held_req_rdata", bus.rdata_o, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
